// File: rtl/fp_div_sched_pkg.sv
// Shared types and helpers for the divider scheduler.
package fp_div_sched_pkg;

    // Tag id field is sized for the widest requester count the scheduler supports.
    localparam int unsigned TAG_ID_W = 8;

    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } div_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from the last winner.
module rr_arbiter
    import fp_div_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int unsigned PTR_W = id_w(N);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] sel;
    logic             found;

    // First requester after the pointer wins; scanning k = N lands back on the pointer itself.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            sel = PTR_W'((32'(ptr_q) + k) % N);
            if (en && !found && req[sel]) begin
                grant[sel] = 1'b1;
                ptr_d      = sel;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_div_scheduler.sv
// Shares one fixed-latency pipelined FP divider between NUM_REQ requesters,
// steering each result back through a tag pipeline that shadows the divider.
module fp_div_scheduler
    import fp_div_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 28,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     hold,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_o,
    output logic [WIDTH-1:0]         div_a,
    output logic [WIDTH-1:0]         div_b,
    output logic                     div_ready,
    output logic                     div_rst,
    input  logic [WIDTH-1:0]         div_o,
    input  logic                     div_valid,
    output logic                     busy,
    output logic                     err_sync
);

    localparam int unsigned ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [ID_W-1:0]    issue_id_q;
    div_tag_t           tag_q [LATENCY];
    div_tag_t           tag_out;
    logic               busy_d;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (~hold & rst_n),
        .grant (grant)
    );

    assign req_ready = grant;
    assign div_rst   = ~rst_n;

    // Encode the one-hot grant and pick the winning operand slices.
    always_comb begin
        grant_id = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                grant_id = ID_W'(i);
                sel_a    = req_a[i*WIDTH +: WIDTH];
                sel_b    = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Issue register; operands hold their last value when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_ready  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            issue_id_q <= '0;
        end else begin
            div_ready <= |grant;
            if (|grant) begin
                div_a      <= sel_a;
                div_b      <= sel_b;
                issue_id_q <= grant_id;
            end
        end
    end

    // Tag shadow pipeline, entered while the divider samples its operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: div_ready, id: TAG_ID_W'(issue_id_q)};
            for (int k = 1; k < int'(LATENCY); k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tag_out = tag_q[LATENCY-1];

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            resp_valid[i] = tag_out.valid && (tag_out.id == TAG_ID_W'(i));
        end
    end

    assign resp_o = div_o;

    // Next-cycle occupancy: what the issue register and tag stages will hold after this edge.
    always_comb begin
        busy_d = (|grant) | div_ready;
        for (int k = 0; k < int'(LATENCY) - 1; k++) begin
            busy_d = busy_d | tag_q[k].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            err_sync <= 1'b0;
        end else begin
            busy     <= busy_d;
            err_sync <= err_sync | (tag_out.valid ^ div_valid);
        end
    end

endmodule

// File: tb/tb_fp_div_scheduler.sv
// Randomised and directed bench for fp_div_scheduler with a behavioural divider and scoreboard.
module tb_fp_div_scheduler;

    localparam int unsigned W = 32;
    localparam int unsigned L = 28;
    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           hold;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_o;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic           div_ready;
    logic           div_rst;
    logic [W-1:0]   div_o;
    logic           div_valid;
    logic           busy;
    logic           err_sync;
    logic           inject;

    fp_div_scheduler #(.WIDTH(W), .LATENCY(L), .NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .hold       (hold),
        .resp_valid (resp_valid),
        .resp_o     (resp_o),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_ready  (div_ready),
        .div_rst    (div_rst),
        .div_o      (div_o),
        .div_valid  (div_valid),
        .busy       (busy),
        .err_sync   (err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Float helpers: single -> real, real -> single (truncating).
    function automatic real sp2r(input logic [31:0] x);
        real m;
        real v;
        if (x[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        v = m * (2.0 ** (real'(int'(x[30:23])) - 127.0));
        return x[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'h0;
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
        return r2sp(sp2r(a) / sp2r(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    // Behavioural divider: fixed latency L, reset by div_rst.
    logic         pv [L];
    logic [W-1:0] pd [L];
    always @(posedge clk or posedge div_rst) begin
        if (div_rst) begin
            for (int k = 0; k < int'(L); k++) begin
                pv[k] <= 1'b0;
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= div_ready;
            pd[0] <= fdiv(div_a, div_b);
            for (int k = 1; k < int'(L); k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end
    assign div_o     = pd[L-1];
    assign div_valid = pv[L-1] | inject;

    // Scoreboard state.
    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  vec;
        logic [31:0] data;
    } ev_t;

    resp_t       sb[$];
    ev_t         glog[$];
    ev_t         rlog[$];
    int          cyc;
    int          m_ptr;
    bit          m_div_ready;
    logic [31:0] m_div_a;
    logic [31:0] m_div_b;
    bit          m_err;
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] model_grant(input logic [3:0] v);
        int idx;
        if (!rst_n || hold) return 4'b0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = (m_ptr + k) % int'(N);
            if (v[idx]) return 4'(1 << idx);
        end
        return 4'b0;
    endfunction

    function automatic int vec2id(input logic [3:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return -1;
    endfunction

    // Compare every output against the model, then advance the model across the coming edge.
    task automatic check_cycle();
        logic [3:0] eg;
        logic [3:0] erv;
        bit         ev;
        int         gid;
        if (!rst_n) begin
            sb.delete();
            m_ptr       = int'(N) - 1;
            m_div_ready = 1'b0;
            m_div_a     = '0;
            m_div_b     = '0;
            m_err       = 1'b0;
        end
        eg  = model_grant(req_valid);
        ev  = (sb.size() > 0) && (sb[0].cyc == cyc);
        erv = ev ? 4'(1 << sb[0].id) : 4'b0;
        chk("req_ready", 64'(req_ready), 64'(eg));
        chk("resp_valid", 64'(resp_valid), 64'(erv));
        if (ev) chk("resp_o", 64'(resp_o), 64'(sb[0].data));
        if (!rst_n) chk("resp_o_rst", 64'(resp_o), 64'h0);
        chk("div_ready", 64'(div_ready), 64'(m_div_ready));
        chk("div_a", 64'(div_a), 64'(m_div_a));
        chk("div_b", 64'(div_b), 64'(m_div_b));
        chk("busy", 64'(busy), 64'(sb.size() != 0));
        chk("err_sync", 64'(err_sync), 64'(m_err));
        if (req_ready != 0) glog.push_back('{cyc, req_ready, 32'h0});
        if (resp_valid != 0) rlog.push_back('{cyc, resp_valid, resp_o});
        if (rst_n) begin
            if (inject && !ev) m_err = 1'b1;
            if (ev) void'(sb.pop_front());
            if (eg != 0) begin
                gid         = vec2id(eg);
                m_div_a     = req_a[gid*W +: W];
                m_div_b     = req_b[gid*W +: W];
                sb.push_back('{cyc + 1 + int'(L), gid, fdiv(m_div_a, m_div_b)});
                m_div_ready = 1'b1;
                m_ptr       = gid;
            end else begin
                m_div_ready = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic step(input bit r, input logic [3:0] v, input bit h, input bit inj,
                        input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        @(negedge clk);
        rst_n     = r;
        req_valid = v;
        hold      = h;
        inject    = inj;
        req_a     = a;
        req_b     = b;
        #1;
        check_cycle();
    endtask

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] x;
        for (int i = 0; i < int'(N); i++) x[i*W +: W] = rand_fp();
        return x;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'b0, 1'b0, 1'b0, rand_vec(), rand_vec());
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0, 1'b0, 1'b0, '0, '0);
    endtask

    int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [3:0] exp_hold [5] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        m_ptr = int'(N) - 1; m_div_ready = 0; m_div_a = '0; m_div_b = '0; m_err = 0;
        rst_n = 1'b0; req_valid = '0; hold = 1'b0; inject = 1'b0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);

        // Reset then idle.
        do_reset(3);
        idle(3);
        chk("idle_busy", 64'(busy), 64'h0);
        chk("idle_err", 64'(err_sync), 64'h0);

        // Single op 6.0 / 2.0 from requester 0.
        glog.delete(); rlog.delete();
        step(1'b1, 4'b0001, 1'b0, 1'b0, {96'h0, 32'h40C00000}, {96'h0, 32'h40000000});
        idle(int'(L) + 6);
        chk("single_grants", 64'(glog.size()), 64'd1);
        chk("single_resps", 64'(rlog.size()), 64'd1);
        if (glog.size() == 1 && rlog.size() == 1) begin
            chk("single_gvec", 64'(glog[0].vec), 64'h1);
            chk("single_lat", 64'(rlog[0].cyc - glog[0].cyc), 64'd29);
            chk("single_rvec", 64'(rlog[0].vec), 64'h1);
            chk("single_data", 64'(rlog[0].data), 64'h40400000);
        end

        // All requesters valid for 8 cycles after a fresh reset.
        do_reset(2);
        glog.delete(); rlog.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 4'b1111, 1'b0, 1'b0, rand_vec(), rand_vec());
        idle(int'(L) + 4);
        chk("rot_grants", 64'(glog.size()), 64'd8);
        chk("rot_resps", 64'(rlog.size()), 64'd8);
        if (glog.size() == 8 && rlog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("rot_gid", 64'(vec2id(glog[i].vec)), 64'(exp_seq[i]));
                chk("rot_rid", 64'(vec2id(rlog[i].vec)), 64'(exp_seq[i]));
                chk("rot_b2b", 64'(rlog[i].cyc - rlog[0].cyc), 64'(i));
            end
        end

        // Requesters 1 and 3 with a 3-cycle hold mid-stream.
        glog.delete(); rlog.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1010, 1'b0, 1'b0, rand_vec(), rand_vec());
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1010, 1'b1, 1'b0, rand_vec(), rand_vec());
        for (int i = 0; i < 2; i++) step(1'b1, 4'b1010, 1'b0, 1'b0, rand_vec(), rand_vec());
        idle(int'(L) + 4);
        chk("hold_grants", 64'(glog.size()), 64'd5);
        chk("hold_resps", 64'(rlog.size()), 64'd5);
        if (glog.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("hold_gvec", 64'(glog[i].vec), 64'(exp_hold[i]));
            chk("hold_gap", 64'(glog[3].cyc - glog[2].cyc), 64'd4);
        end

        // Five issues from one requester, then reset mid-flight.
        glog.delete(); rlog.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0001, 1'b0, 1'b0, rand_vec(), rand_vec());
        chk("b2b_grants", 64'(glog.size()), 64'd5);
        if (glog.size() == 5) chk("b2b_span", 64'(glog[4].cyc - glog[0].cyc), 64'd4);
        do_reset(10);
        idle(int'(L) + 4);
        chk("rst_no_resp", 64'(rlog.size()), 64'd0);
        chk("rst_busy", 64'(busy), 64'h0);
        step(1'b1, 4'b0100, 1'b0, 1'b0, rand_vec(), rand_vec());
        idle(int'(L) + 4);
        chk("post_rst_resps", 64'(rlog.size()), 64'd1);
        if (rlog.size() == 1) chk("post_rst_rvec", 64'(rlog[0].vec), 64'h4);

        // Spurious div_valid with an empty tag pipe.
        step(1'b1, 4'b0, 1'b0, 1'b1, '0, '0);
        idle(5);
        chk("err_sticky", 64'(err_sync), 64'h1);
        do_reset(2);
        idle(1);
        chk("err_cleared", 64'(err_sync), 64'h0);

        // Random traffic with occasional holds.
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 4'($urandom), ($urandom_range(9, 0) == 0), 1'b0, rand_vec(), rand_vec());
        end
        idle(int'(L) + 4);
        chk("final_busy", 64'(busy), 64'h0);
        chk("final_err", 64'(err_sync), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
